// File: rtl/conv3x3_engine.sv
// conv3x3_engine: three-stage pipelined 3x3 convolution with a signed kernel.
// Kernel coefficients are double-buffered. A frame FSM counts output pixels
// and emits a frame_done pulse once the pipeline has drained.
// Handshake: pix_valid qualifies the nine window pixels in the cycle it is high;
// out_valid qualifies out_pixel/out_sat in the cycle it is high. There is no
// ready/backpressure, so every accepted window emits exactly 3 cycles later.
module conv3x3_engine #(
   parameter int DSIZE        = 8,
   parameter int CSIZE        = 8,
   parameter int SHIFT        = 0,
   parameter int ABS_MODE     = 0,
   parameter int IMAGE_WIDTH  = 256,
   parameter int IMAGE_LENGTH = 256,
   localparam int CW          = $clog2(IMAGE_WIDTH * IMAGE_LENGTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    coef_load,
   input  logic [3:0]              coef_addr,
   input  logic signed [CSIZE-1:0] coef_data,
   input  logic                    frame_active,
   input  logic                    pix_valid,
   input  logic [DSIZE-1:0]        pix_0,
   input  logic [DSIZE-1:0]        pix_1,
   input  logic [DSIZE-1:0]        pix_2,
   input  logic [DSIZE-1:0]        pix_3,
   input  logic [DSIZE-1:0]        pix_4,
   input  logic [DSIZE-1:0]        pix_5,
   input  logic [DSIZE-1:0]        pix_6,
   input  logic [DSIZE-1:0]        pix_7,
   input  logic [DSIZE-1:0]        pix_8,
   output logic                    out_valid,
   output logic [DSIZE-1:0]        out_pixel,
   output logic                    out_sat,
   output logic                    frame_done,
   output logic [CW-1:0]           frame_count,
   output logic [1:0]              dbg_state
);
   localparam int PW  = DSIZE + CSIZE + 1;   // product width
   localparam int ACC = DSIZE + CSIZE + 5;   // accumulator width, cannot overflow for 9 terms
   localparam logic signed [CSIZE-1:0] UNITY = CSIZE'(1 << SHIFT);
   localparam logic signed [ACC-1:0]   MAXV  = ACC'((1 << DSIZE) - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   logic [DSIZE-1:0]        w_pix [9];
   logic signed [CSIZE-1:0] r_shadow [9];
   logic signed [CSIZE-1:0] r_active [9];
   logic signed [PW-1:0]    w_px_ext [9];
   logic signed [PW-1:0]    w_cf_ext [9];
   logic signed [PW-1:0]    r_prod [9];
   logic signed [ACC-1:0]   r_row [3];
   logic signed [ACC-1:0]   w_sum, w_shr, w_mag;
   logic [DSIZE-1:0]        w_pix_out, r_out_pixel;
   logic                    w_sat, r_out_sat;
   logic                    r_v1, r_v2, r_out_valid;

   logic                    r_fa_d, w_rise;
   state_t                  r_state, w_next;
   logic [1:0]              r_drain;
   logic                    r_pending;
   logic [CW-1:0]           r_run_cnt, w_cnt_next, r_frame_count;
   logic                    w_commit, w_clear, w_count_en, w_load_drain;
   logic                    w_done_entry, w_set_pending, w_clr_pending;

   assign w_pix[0] = pix_0;
   assign w_pix[1] = pix_1;
   assign w_pix[2] = pix_2;
   assign w_pix[3] = pix_3;
   assign w_pix[4] = pix_4;
   assign w_pix[5] = pix_5;
   assign w_pix[6] = pix_6;
   assign w_pix[7] = pix_7;
   assign w_pix[8] = pix_8;

   function automatic logic signed [ACC-1:0] sx(input logic signed [PW-1:0] v);
      return {{(ACC - PW){v[PW-1]}}, v};
   endfunction

   // Coefficient banks: writes go to shadow; active copies shadow on frame start.
   // On a coincident write the active bank takes the pre-write shadow value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) begin
            r_shadow[i] <= (i == 4) ? UNITY : '0;
            r_active[i] <= (i == 4) ? UNITY : '0;
         end
      end else begin
         if (w_commit) begin
            for (int i = 0; i < 9; i++) r_active[i] <= r_shadow[i];
         end
         if (coef_load && (coef_addr < 4'd9)) r_shadow[coef_addr] <= coef_data;
      end
   end

   // Operand extension: pixel is unsigned (zero-extend), coefficient is signed.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         w_px_ext[i] = {{(PW - DSIZE){1'b0}}, w_pix[i]};
         w_cf_ext[i] = {{(PW - CSIZE){r_active[i][CSIZE-1]}}, r_active[i]};
      end
   end

   // Stages 1 and 2: nine registered products, then three registered row sums.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) r_prod[i] <= '0;
         for (int r = 0; r < 3; r++) r_row[r] <= '0;
      end else begin
         for (int i = 0; i < 9; i++) r_prod[i] <= w_px_ext[i] * w_cf_ext[i];
         for (int r = 0; r < 3; r++) r_row[r] <= sx(r_prod[3*r]) + sx(r_prod[3*r+1]) + sx(r_prod[3*r+2]);
      end
   end

   // Stage 3 combinational: total, arithmetic shift, optional abs, clamp.
   always_comb begin
      w_sum = r_row[0] + r_row[1] + r_row[2];
      w_shr = w_sum >>> SHIFT;
      w_mag = w_shr;
      if ((ABS_MODE != 0) && (w_shr < 0)) w_mag = -w_shr;
      w_pix_out = w_mag[DSIZE-1:0];
      w_sat     = 1'b0;
      if (w_mag < 0) begin
         w_pix_out = '0;
         w_sat     = 1'b1;
      end else if (w_mag > MAXV) begin
         w_pix_out = '1;
         w_sat     = 1'b1;
      end
   end

   // Stage 3 output register plus the 3-deep valid shift that travels with the data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_pixel <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         r_v1        <= pix_valid;
         r_v2        <= r_v1;
         r_out_valid <= r_v2;
         r_out_pixel <= w_pix_out;
         r_out_sat   <= w_sat;
      end
   end

   assign w_rise = frame_active & ~r_fa_d;

   // Frame FSM next-state and control strobes.
   always_comb begin
      w_next        = r_state;
      w_commit      = 1'b0;
      w_clear       = 1'b0;
      w_count_en    = 1'b0;
      w_load_drain  = 1'b0;
      w_done_entry  = 1'b0;
      w_set_pending = 1'b0;
      w_clr_pending = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_next   = RUN;
               w_commit = 1'b1;
               w_clear  = 1'b1;
            end
         end
         RUN: begin
            w_count_en = r_out_valid;
            if (!frame_active) begin
               w_next       = DRAIN;
               w_load_drain = 1'b1;
            end
         end
         DRAIN: begin
            w_count_en    = r_out_valid;
            w_set_pending = w_rise;
            if (r_drain <= 2'd1) begin
               w_next       = DONE;
               w_done_entry = 1'b1;
            end
         end
         DONE: begin
            w_clr_pending = 1'b1;
            if (r_pending || w_rise) begin
               w_next   = RUN;
               w_commit = 1'b1;
               w_clear  = 1'b1;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_cnt_next = w_clear ? '0 : (r_run_cnt + CW'(w_count_en));

   // Frame FSM state, drain counter, pending start and output counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_fa_d        <= 1'b0;
         r_drain       <= 2'd0;
         r_pending     <= 1'b0;
         r_run_cnt     <= '0;
         r_frame_count <= '0;
      end else begin
         r_state   <= w_next;
         r_fa_d    <= frame_active;
         r_run_cnt <= w_cnt_next;
         if (w_load_drain)         r_drain <= 2'd3;
         else if (r_state == DRAIN) r_drain <= r_drain - 2'd1;
         if (w_clr_pending)      r_pending <= 1'b0;
         else if (w_set_pending) r_pending <= 1'b1;
         if (w_done_entry) r_frame_count <= w_cnt_next;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_pixel   = r_out_pixel;
   assign out_sat     = r_out_sat;
   assign frame_done  = (r_state == DONE);
   assign frame_count = r_frame_count;
   assign dbg_state   = r_state;
endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: directed vectors into two builds of the engine sharing one
// input bus: dut_a (SHIFT=0, ABS_MODE=0) and dut_b (SHIFT=4, ABS_MODE=1).
module tb_conv3x3_engine;
   localparam int W  = 20;
   localparam int CW = 17;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic              coef_load, frame_active, pix_valid;
   logic [3:0]        coef_addr;
   logic signed [7:0] coef_data;
   logic [71:0]       pix_flat;
   logic [7:0]        v;

   logic          out_valid_a, out_sat_a, frame_done_a;
   logic [7:0]    out_pixel_a;
   logic [CW-1:0] frame_count_a;
   logic [1:0]    dbg_state_a;
   logic          out_valid_b, out_sat_b, frame_done_b;
   logic [7:0]    out_pixel_b;
   logic [CW-1:0] frame_count_b;
   logic [1:0]    dbg_state_b;

   conv3x3_engine #(.SHIFT(0), .ABS_MODE(0)) dut_a (
      .clk(clk), .rst(rst), .coef_load(coef_load), .coef_addr(coef_addr), .coef_data(coef_data),
      .frame_active(frame_active), .pix_valid(pix_valid),
      .pix_0(pix_flat[7:0]), .pix_1(pix_flat[15:8]), .pix_2(pix_flat[23:16]),
      .pix_3(pix_flat[31:24]), .pix_4(pix_flat[39:32]), .pix_5(pix_flat[47:40]),
      .pix_6(pix_flat[55:48]), .pix_7(pix_flat[63:56]), .pix_8(pix_flat[71:64]),
      .out_valid(out_valid_a), .out_pixel(out_pixel_a), .out_sat(out_sat_a),
      .frame_done(frame_done_a), .frame_count(frame_count_a), .dbg_state(dbg_state_a)
   );

   conv3x3_engine #(.SHIFT(4), .ABS_MODE(1)) dut_b (
      .clk(clk), .rst(rst), .coef_load(coef_load), .coef_addr(coef_addr), .coef_data(coef_data),
      .frame_active(frame_active), .pix_valid(pix_valid),
      .pix_0(pix_flat[7:0]), .pix_1(pix_flat[15:8]), .pix_2(pix_flat[23:16]),
      .pix_3(pix_flat[31:24]), .pix_4(pix_flat[39:32]), .pix_5(pix_flat[47:40]),
      .pix_6(pix_flat[55:48]), .pix_7(pix_flat[63:56]), .pix_8(pix_flat[71:64]),
      .out_valid(out_valid_b), .out_pixel(out_pixel_b), .out_sat(out_sat_b),
      .frame_done(frame_done_b), .frame_count(frame_count_b), .dbg_state(dbg_state_b)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           cyc_q[$];
   int           n_total = 0;
   int           n_bad   = 0;
   bit           mon_on  = 1'b1;

   function automatic logic [W-1:0] ex(input int pa, input bit sa, input int pb, input bit sb);
      return {1'b1, sa, 8'(pa), 1'b1, sb, 8'(pb)};
   endfunction

   function automatic logic [71:0] center(input logic [7:0] c, input logic [7:0] o);
      logic [71:0] r;
      r = {9{o}};
      r[39:32] = c;
      return r;
   endfunction

   function automatic logic [71:0] cols(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
      return {r, m, l, r, m, l, r, m, l};
   endfunction

   // Monitor: pops one expectation per presented output and checks data and latency.
   always @(negedge clk) begin
      logic [W-1:0] got, e;
      int t;
      if (mon_on && (out_valid_a || out_valid_b)) begin
         got = {out_valid_a, out_sat_a, out_pixel_a, out_valid_b, out_sat_b, out_pixel_b};
         n_total++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output got=%h with empty queue at cycle %0d", got, cyc);
         end else begin
            e = exp_q.pop_front();
            t = cyc_q.pop_front();
            if (got !== e) begin
               n_bad++;
               $display("FAIL pixel got={va,sa,pa,vb,sb,pb}=%h expected=%h (issued cycle %0d)", got, e, t);
            end
            n_total++;
            if (cyc - t != 3) begin
               n_bad++;
               $display("FAIL latency got=%0d expected=3", cyc - t);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input int got, input int expv);
      n_total++;
      if (got != expv) begin
         n_bad++;
         $display("FAIL %s got=%0d expected=%0d", name, got, expv);
      end
   endtask

   task automatic send(input logic [71:0] px, input logic [W-1:0] e, input bit push);
      pix_flat  = px;
      pix_valid = 1'b1;
      if (push) begin
         exp_q.push_back(e);
         cyc_q.push_back(cyc);
      end
      @(posedge clk); #1;
      pix_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_coef(input int a, input int d);
      coef_load = 1'b1;
      coef_addr = 4'(a);
      coef_data = 8'(d);
      @(posedge clk); #1;
      coef_load = 1'b0;
   endtask

   // Drops frame_active, optionally re-raises it during DRAIN, and checks the done pulse.
   task automatic end_frame(input int exp_cnt, input bit restart, input string tag);
      int first = 0;
      int pulses = 0;
      int cnt_a = -1;
      int cnt_b = -1;
      int st5 = -1;
      frame_active = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (restart && k == 2) frame_active = 1'b1;
         @(negedge clk);
         if (frame_done_a) begin
            pulses++;
            if (first == 0) begin
               first = k;
               cnt_a = int'(frame_count_a);
               cnt_b = int'(frame_count_b);
            end
         end
         if (k == 5) st5 = int'(dbg_state_a);
      end
      chk({tag, "_done_delay"}, first, 4);
      chk({tag, "_done_pulses"}, pulses, 1);
      chk({tag, "_count_a"}, cnt_a, exp_cnt);
      chk({tag, "_count_b"}, cnt_b, exp_cnt);
      chk({tag, "_state_after"}, st5, restart ? 1 : 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int ev;
      coef_load = 1'b0; coef_addr = '0; coef_data = '0;
      frame_active = 1'b0; pix_valid = 1'b0; pix_flat = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_out_pixel", out_pixel_a, 0);
      chk("rst_out_sat", out_sat_a, 0);
      chk("rst_frame_done", frame_done_a, 0);
      chk("rst_frame_count", frame_count_a, 0);
      chk("rst_state", dbg_state_a, 0);
      chk("rst_out_valid_b", out_valid_b, 0);
      @(posedge clk); #1;

      // Pass-through kernel from reset, issued while IDLE.
      send(center(8'h5A, 8'hFF), ex(8'h5A, 0, 8'h5A, 0), 1);
      idle(5);

      // Frame 2: shadow write mid-frame must not change outputs.
      frame_active = 1'b1;
      idle(1);
      send(center(8'h40, 8'h00), ex(64, 0, 64, 0), 1);
      wr_coef(4, 2);
      send(center(8'h40, 8'h00), ex(64, 0, 64, 0), 1);
      end_frame(2, 0, "f2");

      // Frame 3: rise with coincident write of 3; active gets the earlier 2.
      frame_active = 1'b1;
      coef_load = 1'b1; coef_addr = 4'd4; coef_data = 8'sd3;
      @(posedge clk); #1;
      coef_load = 1'b0;
      send(center(8'h40, 8'h00), ex(128, 0, 8, 0), 1);
      send(center(8'hC8, 8'h00), ex(255, 1, 25, 0), 1);
      for (int i = 0; i < 9; i++) wr_coef(i, 1);
      wr_coef(9, 127);
      wr_coef(13, 127);
      wr_coef(15, -1);
      end_frame(2, 0, "f3");

      // Frame 4: all-ones kernel; load Sobel-x into shadow; restart during DRAIN.
      frame_active = 1'b1;
      idle(1);
      send({9{8'hFF}}, ex(255, 1, 143, 0), 1);
      send({9{8'h10}}, ex(144, 0, 9, 0), 1);
      wr_coef(0, -1); wr_coef(1, 0); wr_coef(2, 1);
      wr_coef(3, -2); wr_coef(4, 0); wr_coef(5, 2);
      wr_coef(6, -1); wr_coef(7, 0); wr_coef(8, 1);
      end_frame(2, 1, "f4");

      // Frame 5: Sobel-x vectors, then uniform windows up to 1000 valids.
      send(cols(8'd128, 8'd0, 8'd0), ex(0, 1, 32, 0), 1);
      send(cols(8'd0, 8'd0, 8'd128), ex(255, 1, 32, 0), 1);
      send(cols(8'd10, 8'd99, 8'd20), ex(40, 0, 2, 0), 1);
      send(cols(8'd20, 8'd99, 8'd10), ex(0, 1, 3, 0), 1);
      for (int i = 0; i < 996; i++) begin
         v = 8'($urandom_range(0, 255));
         send({9{v}}, ex(0, 0, 0, 0), 1);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      end_frame(1000, 0, "f5");

      // Reset during RUN with valids in flight.
      mon_on = 1'b0;
      frame_active = 1'b1;
      idle(1);
      for (int i = 0; i < 4; i++) send({9{8'h55}}, '0, 0);
      pix_flat = {9{8'h55}};
      pix_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pix_valid = 1'b0;
      frame_active = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid_a, 0);
      chk("midrst_state", dbg_state_a, 0);
      chk("midrst_frame_count", frame_count_a, 0);
      ev = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (frame_done_a || out_valid_a || frame_done_b || out_valid_b) ev++;
      end
      chk("midrst_quiet", ev, 0);
      @(posedge clk); #1;
      mon_on = 1'b1;

      // Both banks back to pass-through: check in IDLE and after a commit.
      send(center(8'h33, 8'h77), ex(8'h33, 0, 8'h33, 0), 1);
      idle(4);
      frame_active = 1'b1;
      idle(1);
      send(center(8'h33, 8'h77), ex(8'h33, 0, 8'h33, 0), 1);
      end_frame(1, 0, "f7");

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

Pipelined 3x3 convolution stage that sits directly downstream of the image line buffer. Each cycle it consumes the nine window pixels and their valid flag, multiplies them by a programmable signed kernel, and sums the products. It then shifts, optionally rectifies, and saturates the result to one output pixel. Kernel coefficients are double-buffered so a mid-frame write never corrupts a frame, and per-frame output counting with a frame-done pulse is provided.

## Interface
- DSIZE, 8, pixel width (unsigned)
- CSIZE, 8, coefficient width (signed two's complement)
- SHIFT, 0, arithmetic right shift applied to the sum (normalisation)
- ABS_MODE, 0, 1 = take absolute value before saturation (edge kernels)
- IMAGE_WIDTH, 256, image width in pixels
- IMAGE_LENGTH, 256, image height in pixels
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- coef_load  in  1  write strobe for shadow coefficient bank
- coef_addr  in  4  coefficient index 0..8 (matches pixel index); 9..15 ignored
- coef_data  in  CSIZE  signed coefficient value
- frame_active  in  1  driven by line buffer active_output_frame
- pix_valid  in  1  window valid (line buffer sr_pixel_valid)
- pix_0..pix_8  in  DSIZE each  window pixels, row-major, pix_0 top-left
- out_valid  out  1  out_pixel valid this cycle
- out_pixel  out  DSIZE  convolved, saturated pixel
- out_sat  out  1  clamping occurred for this out_pixel (qualified by out_valid)
- frame_done  out  1  one-cycle pulse after a frame fully drains
- frame_count  out  clog2(IMAGE_WIDTH*IMAGE_LENGTH+1)  out_valid count of last completed frame

## Operation
- Coefficients: shadow bank written by coef_load; active bank used by the datapath. Active bank is loaded from shadow on a detected rising edge of frame_active. If coef_load coincides with that edge, the committed value is the pre-write shadow content. The write lands in shadow only.
- Reset values: both banks all 0 except index 4 = 2^SHIFT (pass-through kernel); all outputs 0; FSM IDLE.
- Arithmetic: pixel zero-extended to DSIZE+1 signed; product width DSIZE+CSIZE+1; accumulator ACC = DSIZE+CSIZE+5 signed, with no overflow possible. Result = sum >>> SHIFT (arithmetic). If ABS_MODE, negate negative results. Clamp to [0, 2^DSIZE-1]. out_sat = 1 iff the clamp changed the value.
- Datapath runs every cycle regardless of FSM state; valid is a 3-deep shift alongside the data. There is no backpressure.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: frame_active rise -> RUN; commit coefficients, clear the running count.
  - RUN: count each out_valid. frame_active low -> DRAIN with drain counter = 3.
  - DRAIN: keep counting out_valid; decrement each cycle; at 0 -> DONE.
  - DONE: frame_done = 1 for one cycle, frame_count <= running count. Next state: RUN if a start is pending, else IDLE.
- A frame_active rise seen in DRAIN or DONE sets a pending-start flag. On leaving DONE it performs the commit and count-clear and enters RUN. frame_done for the old frame is never dropped.
- out_valid pulses in IDLE are not counted.
- rst mid-frame: pipeline valids, FSM, pending flag, counts, and both coefficient banks return to reset values next edge; no frame_done is issued.

## Timing
- Stage 1: nine registered products. Stage 2: three registered row sums. Stage 3: total, shift, abs, clamp, registered output.
- Latency pix_valid -> out_valid is exactly 3 cycles; throughput 1 window/cycle.
- Rise detection uses a registered copy of frame_active, so the commit takes effect on windows arriving ≥1 cycle after the rise edge.
- frame_done is asserted 4 cycles after the cycle frame_active is first sampled low in RUN: 3 drain cycles plus DONE.
- frame_count updates in the same cycle frame_done is high and holds until the next DONE.

## Test plan
- Reset, no coefficient writes, pix_4=0x5A, all others 0xFF, pix_valid=1 -> 3 cycles later out_valid=1, out_pixel=0x5A, out_sat=0.
- All coefficients 1, SHIFT=0, all pixels 0xFF -> out_pixel=0xFF, out_sat=1; with SHIFT=4 (separate build) and sum 2295 -> out_pixel=143, out_sat=0.
- Sobel-x kernel (-1,0,1,-2,0,2,-1,0,1), left column 0x80, right 0x00: ABS_MODE=0 -> 0x00 with out_sat=1; ABS_MODE=1 -> 0xFF with out_sat=1 (512 clamped).
- Write coef 4 = 2 while frame_active high -> outputs unchanged until the next frame_active rise, then doubled.
- Frame of 1000 pix_valid pulses, then frame_active falls -> frame_done pulses 4 cycles later, frame_count=1000. A new frame_active rise during DRAIN -> frame_done is still issued, then RUN resumes with count cleared.
- Assert rst during RUN with valids in flight -> next cycle out_valid=0, frame_done never pulses, coefficients back to the pass-through kernel.
